vec_alu_sequencer: RTL and testbench
====================================

// Module: vec_alu_sequencer
// PURPOSE
//  Vector-op controller for the shared 8-bit ALU. Accepts one command (alufn, length, src A/B, dst bases).
//  Streams elements i=0..len-1: reads A[i] and B[i] from the element register file, drives the ALU,
//  and writes the result to dst[i]. Pulses done when finished, with sticky zero/overflow summary flags.
//  Sits between the instruction decode stage and the combinational ALU plus element register file.
// PARAMETERS
//  ADDR_W  4  element register file address width; all address arithmetic is modulo 2**ADDR_W
//  LEN_W   4  width of the element-count field; max vector length is 2**LEN_W-1
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       sequencer idle; command accepted when cmd_valid && cmd_ready
//  cmd_op     in   6       ALU function code, passed unmodified to alu_fn
//  cmd_len    in   LEN_W   element count (0 = no-op)
//  cmd_src_a  in   ADDR_W  base address of vector A
//  cmd_src_b  in   ADDR_W  base address of vector B
//  cmd_dst    in   ADDR_W  base address of the result vector
//  rd_en      out  1       read strobe; rd_data_* valid exactly 1 cycle later
//  rd_addr_a  out  ADDR_W  read address, port A
//  rd_addr_b  out  ADDR_W  read address, port B
//  rd_data_a  in   8       read data, port A
//  rd_data_b  in   8       read data, port B
//  alu_a      out  8       registered ALU operand a
//  alu_b      out  8       registered ALU operand b
//  alu_fn     out  6       ALU function code
//  alu_en     out  1       ALU enable
//  alu_otp    in   8       ALU result (combinational)
//  alu_zero   in   1       ALU zero flag
//  alu_ovf    in   1       ALU overflow flag
//  wr_en      out  1       result write strobe
//  wr_addr    out  ADDR_W  result write address
//  wr_data    out  8       result write data (= alu_otp)
//  busy       out  1       command in progress (state != IDLE)
//  done       out  1       one-cycle completion pulse
//  all_zero   out  1       sticky: every element result had alu_zero=1
//  any_ovf    out  1       sticky: some element had alu_ovf=1
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0 except cmd_ready=1. Element index=0, latched command cleared.
//  - States:
//      IDLE -accept-> len==0 ? DONE : RD
//      RD -> EX -> WB
//      WB -> (i==len-1 ? DONE : RD with i+1)
//      DONE -> IDLE
//  - cmd_ready = (state==IDLE). On accept: latch op/len/bases, set i=0, all_zero<=1, any_ovf<=0.
//  - RD: rd_en=1, rd_addr_a=src_a+i, rd_addr_b=src_b+i (wrap modulo 2**ADDR_W).
//  - EX: capture rd_data_a/b into alu_a/alu_b at the end of the cycle.
//  - WB: alu_en=1, wr_en=1, wr_addr=dst+i (wraps), wr_data=alu_otp.
//        At the clock edge: all_zero&=alu_zero, any_ovf|=alu_ovf.
//  - alu_fn = latched op while busy, 0 in IDLE. alu_en=0 outside WB. rd_en/wr_en are single-cycle.
//  - Throughput: 3 cycles per element. done is asserted (DONE state) 3*len+1 cycles after accept.
//  - len==0: no rd_en/wr_en; done 1 cycle after accept; all_zero=1, any_ovf=0.
//  - all_zero/any_ovf hold their value after done until the next accept.
//  - A cmd_valid during busy or DONE is not accepted; the earliest accept is the cycle after DONE.
//  - Opcodes undefined in the ALU are passed through unchecked; the result is whatever the ALU returns.
//  - rst mid-operation: abort immediately; no further rd_en/wr_en; no done pulse; flags cleared to 0.
//  - src/dst overlap is allowed. Element i is read before it is written; no hazard within an element.
// CONFIGURATION
//  VSEQ_OVF_ABORT_EN defined:
//    - A WB cycle with alu_ovf=1 still writes that element, then goes to DONE instead of RD.
//    - Remaining elements are neither read nor written; any_ovf=1 at done.
//  VSEQ_OVF_ABORT_EN undefined:
//    - All len elements are always processed; overflow only sets any_ovf.
// TESTING
//  1. rst=1 for 2 cycles, cmd_valid=1 -> no accept; all outputs 0, cmd_ready=1 after release.
//  2. ADD (6'b000000), len=4, A@0=[1,2,3,4], B@4=[10,20,30,40], dst=8
//     -> wr 11,22,33,44 to addresses 8..11; done at accept+13; all_zero=0, any_ovf=0.
//  3. SUB (6'b000001), len=2, A=B=[5,9] -> writes 0,0; all_zero=1.
//  4. ADDR_W=4, src_a=14, src_b=0, dst=15, len=3, AND -> rd_addr_a 14,15,0; wr_addr 15,0,1.
//  5. len=0 with cmd_valid -> accepted; done 1 cycle later; no rd_en/wr_en; cmd_ready=1 the following cycle.
//  6. Stub forces alu_ovf=1 in element 1's WB, len=3:
//     with VSEQ_OVF_ABORT_EN -> 2 writes, done at accept+7;
//     without -> 3 writes, done at accept+10; any_ovf=1 in both cases.
//  7. rst asserted in the EX cycle of element 2 of len=4 -> no further wr_en, no done; cmd_ready=1 after release.

Source files
------------

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: streams one vector command through the shared 8-bit ALU,
// reading A[i]/B[i] from the element register file and writing dst[i].
// Optional feature macro: VSEQ_OVF_ABORT_EN (stop the vector at the first
// element whose ALU result overflows, after writing that element).
module vec_alu_sequencer #(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [7:0]        rd_data_a,
    input  logic [7:0]        rd_data_b,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [5:0]        alu_fn,
    output logic              alu_en,
    input  logic [7:0]        alu_otp,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              all_zero,
    output logic              any_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WB,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [5:0]        r_op;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_srcA;
    logic [ADDR_W-1:0] r_srcB;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_idx;
    logic [7:0]        r_aluA;
    logic [7:0]        r_aluB;
    logic              r_allZero;
    logic              r_anyOvf;

    logic              w_accept;
    logic              w_lastElem;
    logic              w_abort;
    logic [ADDR_W-1:0] w_idx;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_lastElem = (r_idx == (r_len - LEN_W'(1)));
    assign w_idx      = ADDR_W'(r_idx);

`ifdef VSEQ_OVF_ABORT_EN
    assign w_abort = alu_ovf;
`else
    assign w_abort = 1'b0;
`endif

    assign alu_a    = r_aluA;
    assign alu_b    = r_aluB;
    assign all_zero = r_allZero;
    assign any_ovf  = r_anyOvf;

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and per-state strobes; address sums wrap naturally at ADDR_W bits.
    always_comb begin
        w_nextState = r_state;
        cmd_ready   = 1'b0;
        rd_en       = 1'b0;
        rd_addr_a   = '0;
        rd_addr_b   = '0;
        alu_en      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        alu_fn      = (r_state != S_IDLE) ? r_op : 6'd0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_nextState = (cmd_len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                rd_en       = 1'b1;
                rd_addr_a   = r_srcA + w_idx;
                rd_addr_b   = r_srcB + w_idx;
                w_nextState = S_EX;
            end
            S_EX: begin
                w_nextState = S_WB;
            end
            S_WB: begin
                alu_en      = 1'b1;
                wr_en       = 1'b1;
                wr_addr     = r_dst + w_idx;
                wr_data     = alu_otp;
                w_nextState = (w_lastElem || w_abort) ? S_DONE : S_RD;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Command latch, element index, ALU operand registers and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_len     <= '0;
            r_srcA    <= '0;
            r_srcB    <= '0;
            r_dst     <= '0;
            r_idx     <= '0;
            r_aluA    <= '0;
            r_aluB    <= '0;
            r_allZero <= 1'b0;
            r_anyOvf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= cmd_op;
                r_len     <= cmd_len;
                r_srcA    <= cmd_src_a;
                r_srcB    <= cmd_src_b;
                r_dst     <= cmd_dst;
                r_idx     <= '0;
                r_allZero <= 1'b1;
                r_anyOvf  <= 1'b0;
            end
            if (r_state == S_EX) begin
                r_aluA <= rd_data_a;
                r_aluB <= rd_data_b;
            end
            if (r_state == S_WB) begin
                r_allZero <= r_allZero & alu_zero;
                r_anyOvf  <= r_anyOvf | alu_ovf;
                if (!(w_lastElem || w_abort)) begin
                    r_idx <= r_idx + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Testbench for vec_alu_sequencer: register-file and ALU stubs plus a
// scoreboard of expected reads/writes checked as the DUT issues them.
module tb_vec_alu_sequencer;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [5:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [7:0]        rd_data_a;
    logic [7:0]        rd_data_b;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [5:0]        alu_fn;
    logic              alu_en;
    logic [7:0]        alu_otp;
    logic              alu_zero;
    logic              alu_ovf;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              all_zero;
    logic              any_ovf;

    vec_alu_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_en(alu_en),
        .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .all_zero(all_zero), .any_ovf(any_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stub ALU: 0 add (carry = overflow), 1 sub, 2 and, 3 or, others xor.
    function automatic logic [8:0] aluCalc(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'd0:    aluCalc = {1'b0, a} + {1'b0, b};
            6'd1:    aluCalc = {1'b0, a - b};
            6'd2:    aluCalc = {1'b0, a & b};
            6'd3:    aluCalc = {1'b0, a | b};
            default: aluCalc = {1'b0, a ^ b};
        endcase
    endfunction

    logic       forceOvf;
    int         forceIdx;
    int         wbIdx;
    logic [8:0] calc;

    // Combinational ALU stub with an optional forced overflow on one element.
    always_comb begin
        calc     = aluCalc(alu_fn, alu_a, alu_b);
        alu_otp  = calc[7:0];
        alu_zero = (calc[7:0] == 8'd0);
        alu_ovf  = calc[8] || (forceOvf && (wbIdx == forceIdx));
    end

    // Element index of the current writeback, restarted on each accept.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) wbIdx <= 0;
        else if (wr_en)             wbIdx <= wbIdx + 1;
    end

    logic [7:0]        mem [16];
    logic [7:0]        modelMem [16];
    logic              ldEn;
    logic [ADDR_W-1:0] ldAddr;
    logic [7:0]        ldData;

    // Element register file: one-cycle read latency, DUT writes or bench preloads.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
        if (wr_en)     mem[wr_addr] <= wr_data;
        else if (ldEn) mem[ldAddr]  <= ldData;
    end

    typedef struct packed { logic [3:0] a; logic [3:0] b; } rdExp_t;
    typedef struct packed { logic [3:0] addr; logic [7:0] data; } wrExp_t;
    rdExp_t rdQ [$];
    wrExp_t wrQ [$];
    int     wrCount = 0;

    // Scoreboard monitor: every read/write strobe must match the next expectation.
    always @(negedge clk) begin
        rdExp_t re;
        wrExp_t we;
        if (rd_en) begin
            if (rdQ.size() == 0) checkOutput("rd_en_unexpected", 32'(rd_en), 0);
            else begin
                re = rdQ.pop_front();
                checkOutput("rd_addr_a", 32'(rd_addr_a), 32'(re.a));
                checkOutput("rd_addr_b", 32'(rd_addr_b), 32'(re.b));
            end
        end
        if (wr_en) begin
            wrCount++;
            if (wrQ.size() == 0) checkOutput("wr_en_unexpected", 32'(wr_en), 0);
            else begin
                we = wrQ.pop_front();
                checkOutput("wr_addr", 32'(wr_addr), 32'(we.addr));
                checkOutput("wr_data", 32'(wr_data), 32'(we.data));
                checkOutput("alu_en_in_wb", 32'(alu_en), 1);
            end
        end
    end

    task automatic loadWord(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        ldEn   = 1'b1;
        ldAddr = addr;
        ldData = data;
        modelMem[addr] = data;
        @(posedge clk);
        #1 ldEn = 1'b0;
    endtask

    // Predict reads/writes for the first nRd/nWr elements and the resulting flags.
    task automatic pushExpect(input logic [5:0] op, input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] d, input int nRd, input int nWr,
                              output logic expAz, output logic expAo);
        logic [3:0] ra, rb, wa;
        logic [8:0] r;
        logic       ovf;
        int         n;
        expAz = 1'b1;
        expAo = 1'b0;
        n = (nRd > nWr) ? nRd : nWr;
        for (int i = 0; i < n; i++) begin
            ra = sa + 4'(i);
            rb = sb + 4'(i);
            wa = d + 4'(i);
            if (i < nRd) rdQ.push_back('{a: ra, b: rb});
            if (i < nWr) begin
                r   = aluCalc(op, modelMem[ra], modelMem[rb]);
                ovf = r[8] || (forceOvf && (i == forceIdx));
                wrQ.push_back('{addr: wa, data: r[7:0]});
                modelMem[wa] = r[7:0];
                expAz = expAz & (r[7:0] == 8'd0);
                expAo = expAo | ovf;
            end
        end
    endtask

    // Issue one command (cmd_valid held high while busy) and check completion.
    task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [3:0] len,
                                 input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] d,
                                 input int nElem, input int expLat);
        logic expAz, expAo;
        int   startWr, k;
        pushExpect(op, sa, sb, d, nElem, nElem, expAz, expAo);
        startWr = wrCount;
        @(negedge clk);
        checkOutput({tag, "_ready_idle"}, 32'(cmd_ready), 1);
        cmd_op = op; cmd_len = len; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput({tag, "_busy"}, 32'(busy), 1);
                checkOutput({tag, "_alu_fn"}, 32'(alu_fn), 32'(op));
            end
            if (done) break;
            checkOutput({tag, "_ready_busy"}, 32'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        checkOutput({tag, "_done_seen"}, 32'(done), 1);
        checkOutput({tag, "_done_lat"}, 32'(k), 32'(expLat));
        checkOutput({tag, "_all_zero"}, 32'(all_zero), 32'(expAz));
        checkOutput({tag, "_any_ovf"}, 32'(any_ovf), 32'(expAo));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 0);
        checkOutput({tag, "_ready_after"}, 32'(cmd_ready), 1);
        checkOutput({tag, "_all_zero_hold"}, 32'(all_zero), 32'(expAz));
        checkOutput({tag, "_any_ovf_hold"}, 32'(any_ovf), 32'(expAo));
        checkOutput({tag, "_wr_count"}, 32'(wrCount - startWr), 32'(nElem));
        checkOutput({tag, "_wr_q_left"}, 32'(wrQ.size()), 0);
        checkOutput({tag, "_rd_q_left"}, 32'(rdQ.size()), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         doneCnt;
        int         nAbort;
        logic       az, ao;
        logic [5:0] rOp;
        logic [3:0] rLen, rSa, rSb, rD;

        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 6'd0; cmd_len = 4'd3;
        cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        ldEn = 1'b0; ldAddr = '0; ldData = '0; forceOvf = 1'b0; forceIdx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_rd_en", 32'(rd_en), 0);
        checkOutput("rst_wr_en", 32'(wr_en), 0);
        checkOutput("rst_alu_en", 32'(alu_en), 0);
        checkOutput("rst_alu_fn", 32'(alu_fn), 0);
        checkOutput("rst_alu_a", 32'(alu_a), 0);
        checkOutput("rst_alu_b", 32'(alu_b), 0);
        checkOutput("rst_all_zero", 32'(all_zero), 0);
        checkOutput("rst_any_ovf", 32'(any_ovf), 0);

        for (int i = 0; i < 16; i++) loadWord(4'(i), 8'(i * 7 + 3));

        for (int i = 0; i < 4; i++) begin
            loadWord(4'(i), 8'(i + 1));
            loadWord(4'(i + 4), 8'((i + 1) * 10));
        end
        applyStimulus("add4", 6'd0, 4'd4, 4'd0, 4'd4, 4'd8, 4, 12);

        loadWord(4'd12, 8'd5);
        loadWord(4'd13, 8'd9);
        applyStimulus("sub_zero", 6'd1, 4'd2, 4'd12, 4'd12, 4'd2, 2, 6);

        applyStimulus("and_wrap", 6'd2, 4'd3, 4'd14, 4'd0, 4'd15, 3, 9);

        applyStimulus("len0", 6'd3, 4'd0, 4'd1, 4'd2, 4'd3, 0, 0);

        forceOvf = 1'b1;
        forceIdx = 1;
`ifdef VSEQ_OVF_ABORT_EN
        nAbort = 2;
`else
        nAbort = 3;
`endif
        applyStimulus("ovf_elem1", 6'd0, 4'd3, 4'd4, 4'd4, 4'd10, nAbort, 3 * nAbort);
        forceOvf = 1'b0;

        pushExpect(6'd0, 4'd0, 4'd4, 4'd12, 3, 2, az, ao);
        @(negedge clk);
        cmd_op = 6'd0; cmd_len = 4'd4; cmd_src_a = 4'd0; cmd_src_b = 4'd4; cmd_dst = 4'd12;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_ready", 32'(cmd_ready), 1);
        checkOutput("abort_all_zero", 32'(all_zero), 0);
        checkOutput("abort_any_ovf", 32'(any_ovf), 0);
        doneCnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("abort_no_done", 32'(doneCnt), 0);
        checkOutput("abort_wr_q_left", 32'(wrQ.size()), 0);
        checkOutput("abort_rd_q_left", 32'(rdQ.size()), 0);

        for (int t = 0; t < 4; t++) begin
            rOp  = 6'($urandom_range(0, 5));
            rLen = 4'($urandom_range(1, 6));
            rSa  = 4'($urandom_range(0, 15));
            rSb  = 4'($urandom_range(0, 15));
            rD   = 4'($urandom_range(0, 15));
            applyStimulus("rand", rOp, rLen, rSa, rSb, rD, int'(rLen), 3 * int'(rLen));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
